// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning the architectural HI/LO pair.
// A mult/div is evaluated at issue into a pending register. A busy counter
// then models the multi-cycle latency, and the result is committed to HI/LO
// on the edge where the counter reaches zero.
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_rd_sel,
    input  logic        D_is_md,
    output logic        E_busy,
    output logic [31:0] E_md_out,
    output logic        D_md_stall
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;

    // 64-bit extended operands; the divisor is forced to 1 on divide-by-zero
    // so the arithmetic stays defined (that result is never committed).
    logic signed [63:0] a_s, b_s, b_s_safe;
    logic        [63:0] a_u, b_u, b_u_safe;
    logic        [63:0] prod_s, prod_u;
    logic        [31:0] quot_s, rem_s, quot_u, rem_u;
    logic               div_by_zero;

    assign a_s         = {{32{E_A[31]}}, E_A};
    assign b_s         = {{32{E_B[31]}}, E_B};
    assign a_u         = {32'd0, E_A};
    assign b_u         = {32'd0, E_B};
    assign div_by_zero = (E_B == 32'd0);
    assign b_s_safe    = div_by_zero ? 64'sd1 : b_s;
    assign b_u_safe    = div_by_zero ? 64'd1 : b_u;

    // 0x80000000 / -1 is done in 64 bits, so the quotient truncates to 0x80000000.
    assign prod_s = a_s * b_s;
    assign prod_u = a_u * b_u;
    assign quot_s = 32'(a_s / b_s_safe);
    assign rem_s  = 32'(a_s % b_s_safe);
    assign quot_u = 32'(a_u / b_u_safe);
    assign rem_u  = 32'(a_u % b_u_safe);

    // Next-state logic: accept new ops when idle, count down and commit when busy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (E_start) begin
                    case (E_md_op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            pend_wr_d = !div_by_zero;
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            pend_wr_d = !div_by_zero;
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        OP_MTHI: hi_d = E_A;
                        OP_MTLO: lo_d = E_A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = IDLE;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign E_busy     = (state_q == BUSY);
    assign E_md_out   = E_rd_sel ? hi_q : lo_q;
    // E_start covers the issue cycle, before busy is visible.
    assign D_md_stall = D_is_md & (E_start | E_busy);
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the operand values and decoded MD operation issued from the ID/EX pipeline register, and owns the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter. Exports a stall request to the hazard unit, which holds D/F and bubbles E while an MD instruction in D must wait.

Parameters:
- MULT_CYCLES, 5, cycles busy after a mult/multu start.
- DIV_CYCLES, 10, cycles busy after a div/divu start.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- E_start  input  1  one-cycle issue strobe for a valid MD op in E.
- E_md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- E_A  input  32  rs operand (forwarded value).
- E_B  input  32  rt operand (forwarded value).
- E_rd_sel  input  1  0 selects LO, 1 selects HI for mflo/mfhi.
- D_is_md  input  1  instruction in D uses the MDU (mult/div/mthi/mtlo/mfhi/mflo).
- E_busy  output  1  operation in progress.
- E_md_out  output  32  combinational HI or LO per E_rd_sel.
- D_md_stall  output  1  stall request to the hazard unit.

Behaviour:
- Reset (synchronous, clk rising edge): HI=0, LO=0, counter=0, busy=0, pending result cleared.
- States: IDLE (counter==0) and BUSY (counter>0).
- Accept rule: a start is accepted only when E_start=1, busy=0 and op is 1-6. A start while busy, or with op 0/7, is ignored with no state change.
- mult/multu accept:
  - Latch {hi,lo} = signed/unsigned 64-bit product of E_A*E_B into a pending register.
  - Load counter=MULT_CYCLES; busy=1 from the next cycle.
- div/divu accept:
  - Latch pending LO=quotient, HI=remainder, signed or unsigned.
  - Signed semantics: truncate toward zero; remainder takes the dividend's sign.
  - Load counter=DIV_CYCLES.
- Divide by zero: accepted and busy for DIV_CYCLES; HI/LO are left unchanged at completion.
- Signed 0x80000000 / -1 gives LO=0x80000000, HI=0.
- mthi/mtlo accept: HI (or LO) <= E_A at that edge; no busy period.
- BUSY: counter decrements each cycle. On the edge where the counter goes 1->0, HI/LO <= pending result and busy drops the same edge.
  - Example, mult: start edge t0; busy=1 during cycles t0+1..t0+5; HI/LO valid from t0+5 edge.
- E_md_out = E_rd_sel ? HI : LO. It is purely combinational from the registers, with no bypass of the pending result.
- D_md_stall = D_is_md & (E_start | busy).
  - E_start is included because busy is not yet visible in the cycle of issue.
- The hazard unit's bubble into ID/EX guarantees E_start is not re-asserted for the same instruction while stalled.
- Reset mid-operation aborts the op: pending result is discarded; HI=LO=0 after the edge.
- Widths: all arithmetic is done in 64-bit intermediates; operands are sign- or zero-extended per op.

Test Plan:
- mult E_A=0xFFFFFFFE (-2), E_B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div E_A=-7 (0xFFFFFFF9), E_B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1.
- mthi 0x12345678, then mflo/mfhi -> E_md_out=LO old value for sel 0 and 0x12345678 for sel 1, with no busy cycle.
- Stall/overlap:
  - With D_is_md=1, D_md_stall=1 in the start cycle and during all busy cycles, and 0 on the cycle after busy falls.
  - A second E_start during busy is ignored: HI/LO reflect only the first op.
- Reset mid-op: assert reset at busy cycle 3 of a div -> next cycle busy=0, HI=LO=0, and no late write-back afterwards.
- Edge cases:
  - div by 0 with HI=0xAAAA0000, LO=0x5555 preset -> both unchanged after 10 busy cycles.
  - div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
